mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-side responder for the multicycle control unit's memory control lines (MRead, MWrite, MAddr, MDin, SPWrite, PshPop). Owns the PC, SP, IR and MDR registers. Turns each control-unit memory command into a single req/ack transaction on the synchronous memory port and holds the control unit with Stall until the transaction completes. Sits between the control unit/datapath and the unified instruction/data memory.

## Interface
- DATA_W, 16, data and address width
- SP_INIT, 16'hFFFF, SP reset value
- PC_INIT, 16'h0000, PC reset value
- TIMEOUT, 15, maximum cycles in REQ waiting for mem_ack before abort

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- MRead  in  1  read command
- MWrite  in  1  write command
- MAddr  in  2  address select: 00 ALUOut, 01 PC (fetch) or SP+1 (pop), 10 SP (push), 11 AReg
- MDin  in  1  write-data select: 1 BReg, 0 ALUOut
- SPWrite  in  1  access updates SP
- PshPop  in  1  0 push, 1 pop (valid only with SPWrite)
- PCWrite  in  1  fetch: increment PC on completion
- ALUOut, AReg, BReg  in  DATA_W each  datapath operands
- Stall  out  1  command in progress; control unit holds its state and inputs
- PC, SP, IR, MDR  out  DATA_W each  architectural/holding registers
- BusErr  out  1  one-cycle pulse on timeout
- ProtoErr  out  1  one-cycle pulse on illegal command
- mem_req  out  1  memory request
- mem_we  out  1  1 write, 0 read
- mem_addr  out  DATA_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

## Operation
- States: IDLE, REQ, DONE.
- IDLE: MRead xor MWrite starts a command. Address, write data, we, and the op type (fetch/pop/push/plain) are latched. Next state REQ.
- Both MRead and MWrite high: no access. ProtoErr pulses for 1 cycle. Stay in IDLE.
- Address decode, evaluated at latch time:
  - MAddr=01 with SPWrite=0 selects PC.
  - MAddr=01 with SPWrite=1 selects SP+1 (pop).
  - MAddr=10 selects SP.
  - MAddr=00 selects ALUOut.
  - MAddr=11 selects AReg.
- REQ: mem_req=1 and mem_we held constant.
  - mem_ack seen: read data is captured into MDR. A fetch (MRead, MAddr=01, SPWrite=0, PCWrite=1) also captures it into IR. Next state DONE.
  - Timeout counter reaches TIMEOUT with no ack: BusErr pulses, MDR/IR/PC/SP are unchanged, next state IDLE.
- DONE: one cycle. Register side effects commit here:
  - fetch: PC <= PC+1.
  - push (MWrite, SPWrite, PshPop=0): SP <= SP-1.
  - pop (MRead, SPWrite, PshPop=1): SP <= SP+1.
  - Next state IDLE.
- SPWrite combined with MAddr of 00 or 11 is an illegal command: ProtoErr pulses and no access is made.
- PC and SP arithmetic is modulo 2^DATA_W: SP 16'hFFFF+1 wraps to 0, and PC 16'hFFFF wraps to 0.
- Reset values: state IDLE, PC=PC_INIT, SP=SP_INIT, IR=0, MDR=0, Stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, BusErr=0, ProtoErr=0, timeout counter=0.
- Reset asserted mid-transaction abandons it immediately. mem_req is low the cycle after the Reset edge. No PC/SP side effects are committed.

## Timing
- Cycle 0 (IDLE, command present): Stall=1 combinationally; operands are latched at the edge.
- Cycle 1 onward: mem_req=1, with mem_addr/mem_wdata stable until ack.
- mem_ack in cycle n: MDR/IR are valid from cycle n+1 (DONE) and PC/SP are updated from cycle n+2.
- Stall falls in DONE, so the control unit advances at the DONE edge.
- Minimum command latency with zero-wait memory (ack in cycle 1) is 3 cycles from command to Stall low-to-advance.
- mem_ack outside REQ is ignored.
- A new command is accepted only in IDLE. The control unit must hold its inputs while Stall=1.
- Timeout: with mem_ack never asserted, BusErr pulses in cycle TIMEOUT+1 and Stall=0 from the next cycle.

## Test plan
- Reset, then fetch (MRead=1, MAddr=01, PCWrite=1), memory acks in cycle 1 with rdata=16'h3A21 -> mem_addr=0, IR=MDR=16'h3A21, PC=1, Stall high for exactly cycles 0-1.
- Push (MWrite=1, MAddr=10, SPWrite=1, PshPop=0, MDin=1, BReg=16'h00AB) from reset -> write to addr 16'hFFFF with wdata=16'h00AB, then SP=16'hFFFE.
- Pop after that push, with ack delayed 4 cycles and rdata=16'h00AB -> read at addr 16'hFFFF, mem_req held 5 cycles, MDR=16'h00AB, SP=16'hFFFF. A second pop reads addr 0 (SP wrap).
- Store (MWrite=1, MAddr=11, MDin=0, AReg=16'h0040, ALUOut=16'h1234), no ack -> BusErr pulses at cycle 16, SP/PC unchanged, next command accepted.
- MRead and MWrite high together -> ProtoErr single pulse, mem_req stays 0, Stall 0 the next cycle.
- Reset asserted in REQ of a fetch -> mem_req=0 the next cycle, PC=PC_INIT, IR=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Purpose: synchronous req/ack memory port between the memory access unit
//          and the unified instruction/data memory.
// Signals:
//   mem_req    unit -> memory  request, held high until mem_ack
//   mem_we     unit -> memory  1 write, 0 read
//   mem_addr   unit -> memory  address, stable while mem_req is high
//   mem_wdata  unit -> memory  write data, stable while mem_req is high
//   mem_rdata  memory -> unit  read data, valid with mem_ack
//   mem_ack    memory -> unit  one-cycle completion strobe
// Modports: master (access unit side), slave (memory side).
interface mem_access_unit_if #(
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Purpose: memory-side responder for the multicycle control unit. Owns the
//          PC, SP, IR and MDR registers and turns each MRead/MWrite command
//          into one req/ack transaction, holding the control unit with Stall
//          until the transaction is finished.
// Ports:
//   CLK, Reset            clock (rising edge), synchronous active-high reset
//   MRead, MWrite         read / write command (both high is illegal)
//   MAddr                 00 ALUOut, 01 PC or SP+1 (pop), 10 SP, 11 AReg
//   MDin                  write data select: 1 BReg, 0 ALUOut
//   SPWrite, PshPop       stack access, 0 push / 1 pop
//   PCWrite               fetch: increment PC on completion
//   ALUOut, AReg, BReg    datapath operands
//   Stall                 command in progress, control unit must hold
//   PC, SP, IR, MDR       architectural / holding registers
//   BusErr, ProtoErr      one-cycle error pulses (timeout, illegal command)
//   mem                   memory port (master side)
module mem_access_unit #(
   parameter int                DATA_W  = 16,
   parameter logic [DATA_W-1:0] SP_INIT = {DATA_W{1'b1}},
   parameter logic [DATA_W-1:0] PC_INIT = '0,
   parameter int                TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MRead,
   input  logic              MWrite,
   input  logic [1:0]        MAddr,
   input  logic              MDin,
   input  logic              SPWrite,
   input  logic              PshPop,
   input  logic              PCWrite,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] AReg,
   input  logic [DATA_W-1:0] BReg,
   output logic              Stall,
   output logic [DATA_W-1:0] PC,
   output logic [DATA_W-1:0] SP,
   output logic [DATA_W-1:0] IR,
   output logic [DATA_W-1:0] MDR,
   output logic              BusErr,
   output logic              ProtoErr,
   mem_access_unit_if.master mem
);
   localparam int                CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d, sp_q, sp_d, ir_q, ir_d, mdr_q, mdr_d;
   logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic              req_q, req_d, we_q, we_d;
   logic              bus_err_q, bus_err_d, proto_err_q, proto_err_d;
   logic              is_fetch_q, is_fetch_d, is_push_q, is_push_d, is_pop_q, is_pop_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              one_cmd, bad_sp_addr, cmd_start, cmd_illegal;
   logic [DATA_W-1:0] sel_addr;

   always_comb begin
      one_cmd     = MRead ^ MWrite;
      // A stack access can only address SP (push) or SP+1 (pop).
      bad_sp_addr = SPWrite && ((MAddr == 2'b00) || (MAddr == 2'b11));
      cmd_start   = (state_q == S_IDLE) && one_cmd && !bad_sp_addr;
      cmd_illegal = (state_q == S_IDLE) && ((MRead && MWrite) || (one_cmd && bad_sp_addr));

      sel_addr = ALUOut;
      case (MAddr)
         2'b00:   sel_addr = ALUOut;
         2'b01:   sel_addr = SPWrite ? (sp_q + ONE) : pc_q;
         2'b10:   sel_addr = sp_q;
         default: sel_addr = AReg;
      endcase

      state_d     = state_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      ir_d        = ir_q;
      mdr_d       = mdr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      req_d       = req_q;
      we_d        = we_q;
      is_fetch_d  = is_fetch_q;
      is_push_d   = is_push_q;
      is_pop_d    = is_pop_q;
      cnt_d       = cnt_q;
      bus_err_d   = 1'b0;
      proto_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               addr_d     = sel_addr;
               wdata_d    = MDin ? BReg : ALUOut;
               we_d       = MWrite;
               is_fetch_d = MRead && (MAddr == 2'b01) && !SPWrite && PCWrite;
               is_push_d  = MWrite && SPWrite && !PshPop;
               is_pop_d   = MRead && SPWrite && PshPop;
               cnt_d      = '0;
               req_d      = 1'b1;
               state_d    = S_REQ;
            end else if (cmd_illegal) begin
               proto_err_d = 1'b1;
            end
         end
         S_REQ: begin
            if (cnt_q == CNT_LIM) begin
               // BusErr was raised on entry to this cycle; abandon the access.
               req_d   = 1'b0;
               state_d = S_IDLE;
            end else if (mem.mem_ack) begin
               if (!we_q) begin
                  mdr_d = mem.mem_rdata;
                  if (is_fetch_q) ir_d = mem.mem_rdata;
               end
               req_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               cnt_d     = cnt_q + CNT_ONE;
               bus_err_d = (cnt_q + CNT_ONE) == CNT_LIM;
            end
         end
         S_DONE: begin
            // PC/SP side effects commit only once the access has completed.
            if (is_fetch_q) pc_d = pc_q + ONE;
            if (is_push_q)  sp_d = sp_q - ONE;
            if (is_pop_q)   sp_d = sp_q + ONE;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         pc_q        <= PC_INIT;
         sp_q        <= SP_INIT;
         ir_q        <= '0;
         mdr_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         is_fetch_q  <= 1'b0;
         is_push_q   <= 1'b0;
         is_pop_q    <= 1'b0;
         cnt_q       <= '0;
         bus_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         ir_q        <= ir_d;
         mdr_q       <= mdr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_q       <= req_d;
         we_q        <= we_d;
         is_fetch_q  <= is_fetch_d;
         is_push_q   <= is_push_d;
         is_pop_q    <= is_pop_d;
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Stall rises in the command cycle itself and drops in DONE so the
   // control unit advances on the DONE edge.
   assign Stall         = cmd_start || (state_q == S_REQ);
   assign PC            = pc_q;
   assign SP            = sp_q;
   assign IR            = ir_q;
   assign MDR           = mdr_q;
   assign BusErr        = bus_err_q;
   assign ProtoErr      = proto_err_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Purpose: self-checking bench for mem_access_unit. Directed scenarios plus
//          randomized commands, checked against a register-level model of
//          PC/SP/IR/MDR and the expected memory transaction of each command.
module tb_mem_access_unit;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        MRead, MWrite, MDin, SPWrite, PshPop, PCWrite;
   logic [1:0]  MAddr;
   logic [15:0] ALUOut, AReg, BReg;
   logic        Stall, BusErr, ProtoErr;
   logic [15:0] PC, SP, IR, MDR;

   mem_access_unit_if #(.DATA_W(DATA_W)) mbus ();

   mem_access_unit #(
      .DATA_W(DATA_W), .SP_INIT(16'hFFFF), .PC_INIT(16'h0000), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(clk), .Reset(rst), .MRead(MRead), .MWrite(MWrite), .MAddr(MAddr),
      .MDin(MDin), .SPWrite(SPWrite), .PshPop(PshPop), .PCWrite(PCWrite),
      .ALUOut(ALUOut), .AReg(AReg), .BReg(BReg), .Stall(Stall), .PC(PC),
      .SP(SP), .IR(IR), .MDR(MDR), .BusErr(BusErr), .ProtoErr(ProtoErr),
      .mem(mbus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state.
   logic [15:0] m_pc, m_sp, m_ir, m_mdr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 16'h0000;
      m_sp  = 16'hFFFF;
      m_ir  = 16'h0000;
      m_mdr = 16'h0000;
   endtask

   task automatic idle_inputs();
      MRead   = 1'b0;
      MWrite  = 1'b0;
      MAddr   = 2'($urandom);
      MDin    = 1'($urandom);
      SPWrite = 1'($urandom);
      PshPop  = 1'($urandom);
      PCWrite = 1'($urandom);
      ALUOut  = 16'($urandom);
      AReg    = 16'($urandom);
      BReg    = 16'($urandom);
   endtask

   // One control-unit command. dly: cycle (1 = zero wait) in which the memory
   // acks; negative means it never acks.
   task automatic do_cmd(input logic i_rd, input logic i_wr, input logic [1:0] i_ma,
                         input logic i_mdin, input logic i_spw, input logic i_pp,
                         input logic i_pcw, input logic [15:0] i_alu, input logic [15:0] i_a,
                         input logic [15:0] i_b, input int dly, input logic [15:0] rdat);
      logic        illegal, fetch, push, pop;
      logic [15:0] eaddr, ewd;
      illegal = (i_rd && i_wr) || ((i_rd ^ i_wr) && i_spw && (i_ma == 2'b00 || i_ma == 2'b11));
      fetch   = i_rd && !i_wr && (i_ma == 2'b01) && !i_spw && i_pcw;
      push    = i_wr && !i_rd && i_spw && !i_pp;
      pop     = i_rd && !i_wr && i_spw && i_pp;
      case (i_ma)
         2'b00:   eaddr = i_alu;
         2'b01:   eaddr = i_spw ? 16'(m_sp + 16'd1) : m_pc;
         2'b10:   eaddr = m_sp;
         default: eaddr = i_a;
      endcase
      ewd = i_mdin ? i_b : i_alu;

      @(posedge clk); #1;
      mbus.mem_ack = 1'b0;
      MRead = i_rd; MWrite = i_wr; MAddr = i_ma; MDin = i_mdin; SPWrite = i_spw;
      PshPop = i_pp; PCWrite = i_pcw; ALUOut = i_alu; AReg = i_a; BReg = i_b;
      @(negedge clk);
      chk("c0_mdr_keep", 32'(MDR), 32'(m_mdr));
      chk("c0_proto", 32'(ProtoErr), 0);
      if (illegal) begin
         chk("ill_stall0", 32'(Stall), 0);
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         chk("ill_proto", 32'(ProtoErr), 1);
         chk("ill_req", 32'(mbus.mem_req), 0);
         chk("ill_stall1", 32'(Stall), 0);
         @(negedge clk);
         chk("ill_proto_off", 32'(ProtoErr), 0);
         chk("ill_req2", 32'(mbus.mem_req), 0);
         return;
      end
      chk("c0_stall", 32'(Stall), 1);
      chk("c0_req", 32'(mbus.mem_req), 0);

      for (int c = 1; c <= TIMEOUT + 1; c++) begin
         @(posedge clk); #1;
         mbus.mem_ack   = (c == dly);
         mbus.mem_rdata = (c == dly) ? rdat : 16'($urandom);
         @(negedge clk);
         chk("req_hi", 32'(mbus.mem_req), 1);
         chk("req_stall", 32'(Stall), 1);
         chk("req_addr", 32'(mbus.mem_addr), 32'(eaddr));
         chk("req_we", 32'(mbus.mem_we), 32'(i_wr));
         chk("req_wdata", 32'(mbus.mem_wdata), 32'(ewd));
         chk("req_buserr", 32'(BusErr), 32'(dly < 0 && c == TIMEOUT + 1));
         if (c == dly) break;
      end

      @(posedge clk); #1;
      mbus.mem_ack = 1'b0;
      if (dly < 0) begin
         idle_inputs();
         @(negedge clk);
         chk("to_stall", 32'(Stall), 0);
         chk("to_req", 32'(mbus.mem_req), 0);
         chk("to_buserr_off", 32'(BusErr), 0);
         chk("to_pc", 32'(PC), 32'(m_pc));
         chk("to_sp", 32'(SP), 32'(m_sp));
         chk("to_ir", 32'(IR), 32'(m_ir));
         chk("to_mdr", 32'(MDR), 32'(m_mdr));
         return;
      end

      @(negedge clk);
      if (i_rd) m_mdr = rdat;
      if (fetch) m_ir = rdat;
      chk("done_stall", 32'(Stall), 0);
      chk("done_req", 32'(mbus.mem_req), 0);
      chk("done_mdr", 32'(MDR), 32'(m_mdr));
      chk("done_ir", 32'(IR), 32'(m_ir));
      chk("done_pc_old", 32'(PC), 32'(m_pc));
      chk("done_sp_old", 32'(SP), 32'(m_sp));
      if (fetch) m_pc = m_pc + 16'd1;
      if (push)  m_sp = m_sp - 16'd1;
      if (pop)   m_sp = m_sp + 16'd1;

      @(posedge clk); #1;
      idle_inputs();
      // Stray ack while idle must be ignored.
      mbus.mem_ack   = 1'b1;
      mbus.mem_rdata = ~m_mdr;
      @(negedge clk);
      chk("post_pc", 32'(PC), 32'(m_pc));
      chk("post_sp", 32'(SP), 32'(m_sp));
      chk("post_stall", 32'(Stall), 0);
      chk("post_req", 32'(mbus.mem_req), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int          kind, dly;
   logic        rd, wr, mdin, spw, pp, pcw;
   logic [1:0]  ma;

   initial begin
      rst = 1'b1;
      idle_inputs();
      mbus.mem_ack   = 1'b0;
      mbus.mem_rdata = 16'h0000;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_pc", 32'(PC), 32'h0000);
      chk("rst_sp", 32'(SP), 32'hFFFF);
      chk("rst_ir", 32'(IR), 0);
      chk("rst_mdr", 32'(MDR), 0);
      chk("rst_stall", 32'(Stall), 0);
      chk("rst_req", 32'(mbus.mem_req), 0);
      chk("rst_we", 32'(mbus.mem_we), 0);
      chk("rst_addr", 32'(mbus.mem_addr), 0);
      chk("rst_wdata", 32'(mbus.mem_wdata), 0);
      chk("rst_buserr", 32'(BusErr), 0);
      chk("rst_proto", 32'(ProtoErr), 0);

      // Fetch, zero-wait memory.
      do_cmd(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 1, 16'h3A21);
      chk("tp_fetch_ir", 32'(IR), 32'h3A21);
      chk("tp_fetch_mdr", 32'(MDR), 32'h3A21);
      chk("tp_fetch_pc", 32'(PC), 32'h0001);
      // Push BReg.
      do_cmd(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h6666, 16'h00AB, 1, 16'h0000);
      chk("tp_push_sp", 32'(SP), 32'hFFFE);
      // Pop with ack in cycle 5.
      do_cmd(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0303, 5, 16'h00AB);
      chk("tp_pop_mdr", 32'(MDR), 32'h00AB);
      chk("tp_pop_sp", 32'(SP), 32'hFFFF);
      // Second pop reads address 0 and wraps SP.
      do_cmd(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0303, 2, 16'hBEEF);
      chk("tp_pop2_sp", 32'(SP), 32'h0000);
      // Store to AReg that never gets an ack.
      do_cmd(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0040, 16'h7777, -1, 16'h0000);
      chk("tp_to_pc", 32'(PC), 32'h0001);
      // Both MRead and MWrite.
      do_cmd(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         mdin = 1'($urandom); pp = 1'($urandom); pcw = 1'($urandom);
         spw = 1'b0; ma = 2'($urandom); rd = 1'b0; wr = 1'b0;
         dly = $urandom_range(1, 8);
         case (kind)
            0, 1: begin rd = 1'b1; ma = 2'b01; pcw = 1'b1; end
            2:    begin wr = 1'b1; spw = 1'b1; pp = 1'b0; ma = 2'b10; end
            3:    begin rd = 1'b1; spw = 1'b1; pp = 1'b1; ma = 2'b01; end
            4:    rd = 1'b1;
            5:    wr = 1'b1;
            6:    begin rd = 1'b1; wr = 1'b1; end
            7:    begin rd = 1'($urandom); wr = !rd; spw = 1'b1; ma = 1'($urandom) ? 2'b00 : 2'b11; end
            8:    begin rd = 1'b1; ma = 2'b01; pcw = 1'b0; end
            default: begin rd = 1'($urandom); wr = !rd; dly = -1; end
         endcase
         do_cmd(rd, wr, ma, mdin, spw, pp, pcw, 16'($urandom), 16'($urandom),
                16'($urandom), dly, 16'($urandom));
      end

      // Make sure PC is nonzero, then reset in the middle of a fetch.
      do_cmd(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 1, 16'h4242);
      @(posedge clk); #1;
      mbus.mem_ack = 1'b0;
      MRead = 1'b1; MWrite = 1'b0; MAddr = 2'b01; SPWrite = 1'b0; PCWrite = 1'b1;
      @(negedge clk);
      chk("rr_c0_stall", 32'(Stall), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_req", 32'(mbus.mem_req), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rr_req_low", 32'(mbus.mem_req), 0);
      chk("rr_pc", 32'(PC), 32'h0000);
      chk("rr_ir", 32'(IR), 0);
      chk("rr_sp", 32'(SP), 32'hFFFF);
      chk("rr_stall", 32'(Stall), 0);
      // A fresh fetch still works after the abandoned one.
      do_cmd(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 3, 16'h5A5A);
      chk("rr_fetch_pc", 32'(PC), 32'h0001);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
